// File: rtl/ps2_rx_port_if.sv
// Bundle between the PS/2 receiver and the VIA port A side.
// master = receiver (drives scancode/status), slave = host side (drives PS/2 lines and ack).
interface ps2_rx_port_if;
    logic       ps2_clk;
    logic       ps2_dat;
    logic       ack;
    logic [7:0] data;
    logic       ready;
    logic       strobe;
    logic       err;
    logic       overrun;

    modport master (
        input  ps2_clk, ps2_dat, ack,
        output data, ready, strobe, err, overrun
    );

    modport slave (
        output ps2_clk, ps2_dat, ack,
        input  data, ready, strobe, err, overrun
    );
endinterface

// File: rtl/ps2_rx_port.sv
// PS/2 keyboard receiver presenting scancode bytes as a VIA port A input source.
// Optional odd-parity checking is enabled by defining PS2_PARITY_CHECK_EN.
module ps2_rx_port #(
    parameter int unsigned FILTER_LEN     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic          clk,
    input  logic          rst,
    ps2_rx_port_if.master bus
);
    localparam int unsigned FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

    logic          r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
    logic          r_clk_f;
    logic [FW-1:0] r_flt_cnt;
    logic          w_flt_full;
    logic          w_fall;

    state_e        r_state;
    logic [2:0]    r_bit_cnt;
    logic [7:0]    r_shreg;
    logic [TW-1:0] r_to_cnt;
    logic [7:0]    r_data;
    logic          r_ready, r_strobe, r_err, r_overrun;
    logic          w_par_ok;

    assign w_flt_full = (r_flt_cnt == FW'(FILTER_LEN - 1));
    // Fall is the cycle the filtered level is about to flip from 1 to 0.
    assign w_fall     = r_clk_f & ~r_clk_s2 & w_flt_full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_clk_s1  <= 1'b1;
            r_clk_s2  <= 1'b1;
            r_dat_s1  <= 1'b1;
            r_dat_s2  <= 1'b1;
            r_clk_f   <= 1'b1;
            r_flt_cnt <= '0;
        end else begin
            r_clk_s1 <= bus.ps2_clk;
            r_clk_s2 <= r_clk_s1;
            r_dat_s1 <= bus.ps2_dat;
            r_dat_s2 <= r_dat_s1;
            if (r_clk_s2 == r_clk_f) begin
                r_flt_cnt <= '0;
            end else if (w_flt_full) begin
                r_clk_f   <= r_clk_s2;
                r_flt_cnt <= '0;
            end else begin
                r_flt_cnt <= r_flt_cnt + 1'b1;
            end
        end
    end

`ifdef PS2_PARITY_CHECK_EN
    logic r_parity;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_parity <= 1'b0;
        end else if (w_fall && r_state == StParity) begin
            r_parity <= r_dat_s2;
        end
    end

    // Odd parity across the eight data bits and the parity bit.
    assign w_par_ok = ^{r_shreg, r_parity};
`else
    assign w_par_ok = 1'b1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= StIdle;
            r_bit_cnt <= '0;
            r_shreg   <= '0;
            r_to_cnt  <= '0;
            r_data    <= '0;
            r_ready   <= 1'b0;
            r_strobe  <= 1'b0;
            r_err     <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_strobe <= 1'b0;
            r_err    <= 1'b0;
            if (bus.ack) begin
                r_ready   <= 1'b0;
                r_overrun <= 1'b0;
            end

            if (r_state == StIdle || w_fall) begin
                r_to_cnt <= '0;
            end else if (r_to_cnt != TW'(TIMEOUT_CYCLES)) begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end

            if (w_fall) begin
                unique case (r_state)
                    StIdle: begin
                        if (!r_dat_s2) begin
                            r_state   <= StData;
                            r_bit_cnt <= '0;
                        end
                    end
                    StData: begin
                        r_shreg   <= {r_dat_s2, r_shreg[7:1]};
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                        if (r_bit_cnt == 3'd7) begin
                            r_state <= StParity;
                        end
                    end
                    StParity: r_state <= StStop;
                    StStop: begin
                        r_state <= StIdle;
                        if (r_dat_s2 && w_par_ok) begin
                            // A pending unread byte wins unless it is being read right now.
                            if (!r_ready || bus.ack) begin
                                r_data   <= r_shreg;
                                r_ready  <= 1'b1;
                                r_strobe <= 1'b1;
                            end else begin
                                r_overrun <= 1'b1;
                            end
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                    default: r_state <= StIdle;
                endcase
            end else if (r_state != StIdle && r_to_cnt == TW'(TIMEOUT_CYCLES)) begin
                r_state   <= StIdle;
                r_bit_cnt <= '0;
                r_to_cnt  <= '0;
                r_err     <= 1'b1;
            end
        end
    end

    assign bus.data    = r_data;
    assign bus.ready   = r_ready;
    assign bus.strobe  = r_strobe;
    assign bus.err     = r_err;
    assign bus.overrun = r_overrun;
endmodule
